// File: rtl/cba_pkg.sv
// cba_pkg: shared definitions for the carry-bypass operand sequencer.
//   ADD_W_DEF     default width of the external adder
//   ST_*          sequencer state encoding
//   ovf_rule()    two's-complement overflow from operand and sum MSBs
package cba_pkg;

  localparam int ADD_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Overflow happens only when both operands share a sign and the sum's
  // sign differs from it.
  function automatic logic ovf_rule(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/carrybypass.sv
// carrybypass: combinational carry-bypass (carry-skip) adder.
//   i_a, i_b  W-bit operands
//   i_cin     carry in
//   o_s       W-bit sum
//   o_cout    carry out
// Ripples inside BLK-bit blocks; a block whose bits all propagate passes its
// incoming carry straight to the next block. W must be a multiple of BLK.
module carrybypass #(
  parameter int W   = 16,
  parameter int BLK = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout
);

  localparam int NB = W / BLK;

  always_comb begin
    logic w_c, w_rc, w_p, w_pb;
    int   idx;
    o_s  = '0;
    w_c  = i_cin;
    w_rc = 1'b0;
    w_p  = 1'b0;
    w_pb = 1'b0;
    idx  = 0;
    for (int b = 0; b < NB; b++) begin
      w_rc = w_c;
      w_p  = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        idx      = b * BLK + i;
        w_pb     = i_a[idx] ^ i_b[idx];
        o_s[idx] = w_pb ^ w_rc;
        w_rc     = (i_a[idx] & i_b[idx]) | (w_pb & w_rc);
        w_p      = w_p & w_pb;
      end
      // Full-propagate block: skip the ripple and forward the block carry-in.
      w_c = w_p ? w_c : w_rc;
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/cba_add32_seq.sv
// cba_add32_seq: feeds a wide add through an external ADD_W-bit adder one
// slice per cycle (LSB first, carry chained) and returns the wide result.
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           operand handshake (in_a, in_b, in_cin)
//   add_a/add_b/add_cin         registered slice drive to the adder
//   add_s/add_cout              adder result for the current slice
//   out_valid/out_ready         result handshake (out_sum, out_cout, out_ovf)
module cba_add32_seq
  import cba_pkg::*;
#(
  parameter int ADD_W = ADD_W_DEF,
  parameter int NSEG  = 2,
  localparam int W    = ADD_W * NSEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_cin,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_cin,
  input  logic [ADD_W-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int              SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SEG_W-1:0] LAST = SEG_W'(NSEG - 1);

  logic [1:0]       r_state;
  logic [SEG_W-1:0] r_seg;
  logic [W-1:0]     r_a, r_b, r_sum;
  logic [ADD_W-1:0] r_add_a, r_add_b;
  logic             r_add_cin, r_cout, r_ovf, r_live;
  logic             w_accept;

  // r_live holds in_ready low until the first edge after reset release.
  assign in_ready  = r_live && ((r_state == ST_IDLE) ||
                                ((r_state == ST_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_seg     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        // Slice 0 is loaded into the drive registers here so the adder
        // sees it on the first EXEC cycle without any in_* -> add_* path.
        r_a       <= in_a;
        r_b       <= in_b;
        r_add_a   <= in_a[ADD_W-1:0];
        r_add_b   <= in_b[ADD_W-1:0];
        r_add_cin <= in_cin;
        r_seg     <= '0;
        r_state   <= ST_EXEC;
      end else begin
        case (r_state)
          ST_EXEC: begin
            r_sum[int'(r_seg)*ADD_W +: ADD_W] <= add_s;
            if (r_seg == LAST) begin
              // Drive registers keep the last slice; only results update.
              r_cout  <= add_cout;
              r_ovf   <= ovf_rule(r_a[W-1], r_b[W-1], add_s[ADD_W-1]);
              r_state <= ST_DONE;
            end else begin
              r_add_a   <= r_a[(int'(r_seg)+1)*ADD_W +: ADD_W];
              r_add_b   <= r_b[(int'(r_seg)+1)*ADD_W +: ADD_W];
              r_add_cin <= add_cout;
              r_seg     <= r_seg + 1'b1;
            end
          end
          ST_DONE: if (out_ready) r_state <= ST_IDLE;
          ST_IDLE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cba_add32_seq.sv
module tb_cba_add32_seq;

  localparam int ADD_W = 16;
  localparam int NSEG  = 2;
  localparam int W     = ADD_W * NSEG;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_cin;
  logic [W-1:0]     in_a, in_b;
  logic [ADD_W-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0]     out_sum;

  int n_chk  = 0;
  int n_fail = 0;

  cba_add32_seq #(.ADD_W(ADD_W), .NSEG(NSEG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  carrybypass #(.W(ADD_W)) u_add (
    .i_a(add_a), .i_b(add_b), .i_cin(add_cin),
    .o_s(add_s), .o_cout(add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic c);
    logic [W:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {o, t};
  endfunction

  // Offers one op with out_ready low. lat counts cycles from the handshake
  // cycle (0) to the first cycle showing out_valid; result is left pending.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output logic [W-1:0] s,
                        output logic co, output logic ov, output int lat);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 50) begin @(negedge clk); #1; lat++; end
    s = out_sum; co = out_cout; ov = out_ovf;
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_sum !== '0) begin n_fail++; $display("FAIL rst_out_sum: got %h want 0", out_sum); end
    n_chk++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL rst_out_cout: got %b want 0", out_cout); end
    n_chk++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_out_ovf: got %b want 0", out_ovf); end
    n_chk++; if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin n_fail++; $display("FAIL rst_add: got %h %h %b want 0 0 0", add_a, add_b, add_cin); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co, ov; int lat;
    run_op(32'h0001FFFF, 32'h00000001, 1'b0, s, co, ov, lat);
    n_chk++; if (s !== 32'h00020000) begin n_fail++; $display("FAIL basic_sum: got %h want 00020000", s); end
    n_chk++; if (co !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", co); end
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ov); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
    drain();
  endtask

  task automatic test_bypass();
    logic [W-1:0] s; logic co, ov; int lat;
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, s, co, ov, lat);
    n_chk++; if (s !== 32'h00000000) begin n_fail++; $display("FAIL bypass_sum: got %h want 00000000", s); end
    n_chk++; if (co !== 1'b1) begin n_fail++; $display("FAIL bypass_cout: got %b want 1", co); end
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL bypass_ovf: got %b want 0", ov); end
    drain();
  endtask

  task automatic test_ovf();
    logic [W-1:0] s; logic co, ov; int lat;
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, s, co, ov, lat);
    n_chk++; if (s !== 32'h80000000) begin n_fail++; $display("FAIL ovf_pos_sum: got %h want 80000000", s); end
    n_chk++; if (co !== 1'b0) begin n_fail++; $display("FAIL ovf_pos_cout: got %b want 0", co); end
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_ovf: got %b want 1", ov); end
    drain();
    run_op(32'h80000000, 32'h80000000, 1'b0, s, co, ov, lat);
    n_chk++; if (s !== 32'h00000000) begin n_fail++; $display("FAIL ovf_neg_sum: got %h want 00000000", s); end
    n_chk++; if (co !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_cout: got %b want 1", co); end
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_ovf: got %b want 1", ov); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s; logic co, ov; int lat;
    run_op(32'h12345678, 32'h11111111, 1'b0, s, co, ov, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_chk++; if (out_valid !== 1'b1 || out_sum !== 32'h23456789 || out_cout !== 1'b0)
        begin n_fail++; $display("FAIL hold_out[%0d]: got v=%b s=%h c=%b want v=1 s=23456789 c=0", k, out_valid, out_sum, out_cout); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    @(negedge clk);
    in_a = 32'hDEADBEEF; in_b = 32'h21524111; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    lat = 1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consumed: got %b want 0", out_valid); end
    while (!out_valid && lat < 50) begin @(negedge clk); #1; lat++; end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    n_chk++; if ({out_ovf, out_cout, out_sum} !== {1'b0, 1'b1, 32'h00000000})
      begin n_fail++; $display("FAIL b2b_result: got o=%b c=%b s=%h want o=0 c=1 s=00000000", out_ovf, out_cout, out_sum); end
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_a = 32'h0000FFFF; in_b = 32'h00000001; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);               // first EXEC cycle
    in_valid = 1'b0;
    @(negedge clk);               // second EXEC cycle
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_chk++; if (add_a !== '0 || add_cin !== 1'b0) begin n_fail++; $display("FAIL midrst_add: got %h %b want 0 0", add_a, add_cin); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result[%0d]: got %b want 0", k, out_valid); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    logic         pend;
    int           sent, got, cyc;
    pend = 1'b0; sent = 0; got = 0; cyc = 0;
    while ((sent < 2000 || pend || exp_q.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < 2000 && $urandom_range(0, 9) < 7) begin
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: in_a = '1;
          1: in_b = ~in_a;
          2: begin in_a = 32'h7FFFFFFF; in_b = $urandom_range(0, 3); end
          default: ;
        endcase
        pend = 1'b1;
      end
      in_valid  = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        got++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got s=%h with nothing expected", out_sum);
        end else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_cout, out_sum} !== e) begin
            n_fail++;
            $display("FAIL rand_result[%0d]: got o=%b c=%b s=%h want o=%b c=%b s=%h",
                     got, out_ovf, out_cout, out_sum, e[W+1], e[W], e[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(in_a, in_b, in_cin));
        sent++;
        pend = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_chk++; if (got !== 2000 || exp_q.size() != 0)
      begin n_fail++; $display("FAIL rand_count: got %0d results (%0d pending) want 2000 (0)", got, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
